gate_truth_checker: RTL and testbench
=====================================

Name: gate_truth_checker

Overview:
- Self-running stimulus-and-check stage wrapped around the basic two-input gate block.
- Drives the gate inputs a/b through all four vectors 00, 01, 10, 11 in order and waits a programmable settle time per vector.
- Samples the AND/OR/XOR/NOT outputs and compares them against the golden truth table.
- Reports pass/fail, error count, a per-gate failure mask and the first failing vector through a start/busy/done handshake.

Parameters:
- SETTLE_CYCLES, 2, cycles in SETTLE per vector before sampling; legal range 0..15.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  run request; sampled only in IDLE.
- abort  input  1  cancels a run in progress; returns to IDLE without done.
- a_out  output  1  drives gate input a.
- b_out  output  1  drives gate input b.
- and_in  input  1  gate AND output.
- or_in  input  1  gate OR output.
- xor_in  input  1  gate XOR output.
- not_in  input  1  gate NOT output (~a).
- busy  output  1  high from the cycle after start is accepted until DONE is left.
- done  output  1  one-cycle pulse at the end of a completed run.
- pass  output  1  1 when the last completed run had zero errors; held until the next accepted start.
- err_cnt  output  3  number of failing vectors in the current or last run, 0..4.
- fail_mask  output  4  sticky per-gate failure flags: [3]=AND, [2]=OR, [1]=XOR, [0]=NOT.
- first_fail  output  2  {a,b} of the first failing vector; valid only when err_cnt!=0.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - a_out=0, b_out=0.
  - busy=0, done=0, pass=0, err_cnt=0, fail_mask=0, first_fail=0.
  - Settle counter=0, vector index=0.
  - Reset asserted mid-run aborts immediately; no done pulse.
- States: IDLE, DRIVE, SETTLE, CHECK, DONE.
- IDLE:
  - start=1 -> DRIVE.
  - On that edge: vector index=0, err_cnt=0, fail_mask=0, first_fail=0, pass=0.
- DRIVE (1 cycle):
  - {a_out,b_out}=vector index is registered on entry and held stable until the next DRIVE.
  - If SETTLE_CYCLES=0 -> CHECK; else -> SETTLE with counter=0.
- SETTLE:
  - Counter increments each cycle.
  - When counter==SETTLE_CYCLES-1 -> CHECK.
- CHECK (1 cycle): samples gate outputs against the expected values:
  - expected = {a&b, a|b, a^b, ~a} for the current a_out/b_out.
  - Comparison is 4-state; X or Z on any input counts as a mismatch.
  - On any mismatch:
    - err_cnt += 1.
    - fail_mask |= per-bit mismatch.
    - If err_cnt was 0, first_fail={a_out,b_out}.
  - If vector index==3 -> DONE; else vector index += 1 -> DRIVE.
- DONE (1 cycle):
  - done=1.
  - pass=(err_cnt==0), with the CHECK update of vector 11 included.
  - -> IDLE.
- busy:
  - 1 in DRIVE, SETTLE, CHECK and DONE; 0 in IDLE.
  - Registered so it is visible from the first DRIVE cycle.
- Run latency:
  - Each vector takes 2+SETTLE_CYCLES cycles.
  - done is high 4*(2+SETTLE_CYCLES) cycles after the edge that accepts start.
  - With the default, done appears at edge 16 after acceptance and lasts exactly one cycle.
- start while busy, including the DONE cycle, is ignored; no queuing.
- start held high continuously:
  - A new run begins on the IDLE cycle after DONE.
  - Results of the previous run are cleared on that acceptance edge.
- abort:
  - In any non-IDLE state, forces IDLE on the next edge.
  - busy drops and done stays 0.
  - err_cnt, fail_mask and first_fail keep their partial values; pass stays 0.
  - abort together with start in IDLE: abort wins and the run does not start.
- err_cnt never exceeds 4; no wrap.
- a_out/b_out keep their last value (11 after a full run) in IDLE.

Test Plan:
- Correct gates, default params, start pulse -> a/b sequence 00,01,10,11 each held 4 cycles; done at acceptance+16; pass=1, err_cnt=0, fail_mask=0000.
- XOR output stuck at 0 -> err_cnt=2, fail_mask=0010, first_fail=01, pass=0.
- NOT output inverted (equals a) -> err_cnt=4, fail_mask=0001, first_fail=00, pass=0.
- abort asserted during the SETTLE of vector 10 with AND stuck at 1 -> IDLE next cycle, done never pulses, err_cnt=2, fail_mask=1000, pass=0; a following start clears the counts and reruns.
- SETTLE_CYCLES=0 and start held high -> per-vector period 2 cycles, done at acceptance+8; second run accepted in the IDLE cycle after DONE.
- rst_n pulled low in the CHECK of vector 01 -> all outputs 0 immediately; no done pulse after release.

Source files
------------

// File: rtl/gate_truth_checker.sv
// Self-running exhaustive checker for a two-input AND/OR/XOR/NOT gate block.
// Steps a/b through 00,01,10,11, waits SETTLE_CYCLES per vector, then scores the outputs.
module gate_truth_checker #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       a_out,
  output logic       b_out,
  input  logic       and_in,
  input  logic       or_in,
  input  logic       xor_in,
  input  logic       not_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [3:0] fail_mask,
  output logic [1:0] first_fail
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [3:0] SETTLE_LAST =
    (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

  state_t     state, state_n;
  logic [1:0] vec, vec_n;
  logic [3:0] cnt, cnt_n;
  logic [3:0] expected, mism;
  logic       accept, check_upd, any_mism;

  always_comb begin
    state_n = state;
    vec_n   = vec;
    cnt_n   = cnt;
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          state_n = S_DRIVE;
          vec_n   = 2'd0;
        end
      end
      S_DRIVE: begin
        if (abort) begin
          state_n = S_IDLE;
        end else if (SETTLE_CYCLES == 0) begin
          state_n = S_CHECK;
        end else begin
          state_n = S_SETTLE;
          cnt_n   = 4'd0;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          state_n = S_IDLE;
        end else if (cnt == SETTLE_LAST) begin
          state_n = S_CHECK;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      S_CHECK: begin
        if (abort) begin
          state_n = S_IDLE;
        end else if (vec == 2'd3) begin
          state_n = S_DONE;
        end else begin
          vec_n   = vec + 2'd1;
          state_n = S_DRIVE;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Four-state compare so an X or Z from the gate block is scored as a failure.
  always_comb begin
    expected  = {a_out & b_out, a_out | b_out, a_out ^ b_out, ~a_out};
    mism[3]   = (and_in !== expected[3]);
    mism[2]   = (or_in  !== expected[2]);
    mism[1]   = (xor_in !== expected[1]);
    mism[0]   = (not_in !== expected[0]);
    any_mism  = |mism;
    accept    = (state == S_IDLE) && start && !abort;
    check_upd = (state == S_CHECK) && !abort;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      vec        <= 2'd0;
      cnt        <= 4'd0;
      a_out      <= 1'b0;
      b_out      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= 3'd0;
      fail_mask  <= 4'd0;
      first_fail <= 2'd0;
    end else begin
      state <= state_n;
      vec   <= vec_n;
      cnt   <= cnt_n;
      busy  <= (state_n != S_IDLE);
      done  <= (state_n == S_DONE);
      if (state_n == S_DRIVE) begin
        {a_out, b_out} <= vec_n;
      end
      if (accept) begin
        err_cnt    <= 3'd0;
        fail_mask  <= 4'd0;
        first_fail <= 2'd0;
        pass       <= 1'b0;
      end else if (check_upd && any_mism) begin
        if (err_cnt != 3'd4) begin
          err_cnt <= err_cnt + 3'd1;
        end
        fail_mask <= fail_mask | mism;
        if (err_cnt == 3'd0) begin
          first_fail <= {a_out, b_out};
        end
      end
      // Only CHECK of the last vector leads here, so fold in its result.
      if (state_n == S_DONE) begin
        pass <= (err_cnt == 3'd0) && !any_mism;
      end
    end
  end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed bench: two checker instances (default settle and zero settle) driving
// behavioural gate models with selectable injected faults.
module tb_gate_truth_checker;

  logic clk = 1'b0;
  logic rst_n;
  logic start0, abort0, start1, abort1;
  logic a0, b0, and0, or0, xor0, not0, busy0, done0, pass0;
  logic a1, b1, and1, or1, xor1, not1, busy1, done1, pass1;
  logic [2:0] err0, err1;
  logic [3:0] mask0, mask1;
  logic [1:0] first0, first1;
  int fault0, fault1;
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Fault codes: 1 = XOR stuck 0, 2 = NOT equals a, 3 = AND stuck 1.
  function automatic logic [3:0] gate(input logic a, input logic b, input int fault);
    logic [3:0] g;
    g = {a & b, a | b, a ^ b, ~a};
    case (fault)
      1: g[1] = 1'b0;
      2: g[0] = a;
      3: g[3] = 1'b1;
      default: ;
    endcase
    return g;
  endfunction

  assign {and0, or0, xor0, not0} = gate(a0, b0, fault0);
  assign {and1, or1, xor1, not1} = gate(a1, b1, fault1);

  gate_truth_checker u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
    .a_out(a0), .b_out(b0), .and_in(and0), .or_in(or0), .xor_in(xor0), .not_in(not0),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
    .fail_mask(mask0), .first_fail(first0)
  );

  gate_truth_checker #(.SETTLE_CYCLES(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .a_out(a1), .b_out(b1), .and_in(and1), .or_in(or1), .xor_in(xor1), .not_in(not1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
    .fail_mask(mask1), .first_fail(first1)
  );

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Leaves the bench at the falling edge just after the accepting rising edge.
  task automatic pulse_start0();
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
  endtask

  task automatic wait_done0(input int limit, output int cyc);
    cyc = 0;
    while (done0 !== 1'b1 && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Summary of dut0 results: {busy,done,pass,err[2:0],mask[3:0],first[1:0]}.
  function automatic logic [15:0] res0();
    return {4'd0, busy0, done0, pass0, err0, mask0, first0};
  endfunction

  initial begin
    int cyc;
    int seen;
    rst_n = 1'b0; start0 = 0; abort0 = 0; start1 = 0; abort1 = 0;
    fault0 = 0; fault1 = 0;
    repeat (3) @(negedge clk);
    check_output("reset_state", {a0, b0, res0()[11:0]}, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] correct gates, default settle");
    pulse_start0();
    check_output("t1_first_drive", {busy0, done0, a0, b0}, 16'b1000);
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      check_output($sformatf("t1_seq_%0d", k), {done0, a0, b0}, 16'(k / 4));
    end
    @(negedge clk);
    check_output("t1_done_at_16", {busy0, done0, a0, b0}, 16'b1111);
    @(negedge clk);
    check_output("t1_result", res0(), {4'd0, 3'b001, 3'd0, 4'b0000, 2'b00});
    check_output("t1_idle_ab", {a0, b0}, 16'b11);

    $display("[TB] XOR stuck at 0");
    fault0 = 1;
    pulse_start0();
    check_output("t2_cleared", {pass0, err0, mask0}, 16'd0);
    wait_done0(40, cyc);
    check_output("t2_latency", 16'(cyc), 16'd16);
    @(negedge clk);
    check_output("t2_result", res0(), {4'd0, 3'b000, 3'd2, 4'b0010, 2'b01});

    $display("[TB] NOT equals a");
    fault0 = 2;
    pulse_start0();
    wait_done0(40, cyc);
    check_output("t3_latency", 16'(cyc), 16'd16);
    check_output("t3_done_pass", {done0, pass0}, 16'b10);
    @(negedge clk);
    check_output("t3_result", res0(), {4'd0, 3'b000, 3'd4, 4'b0001, 2'b00});

    $display("[TB] abort during settle of vector 10, AND stuck at 1");
    fault0 = 3;
    pulse_start0();
    repeat (9) @(negedge clk);
    check_output("t4_in_vec10", {busy0, a0, b0}, 16'b110);
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    check_output("t4_aborted", res0(), {4'd0, 3'b000, 3'd2, 4'b1000, 2'b00});
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done0 !== 1'b0 || busy0 !== 1'b0) seen++;
    end
    check_output("t4_no_done", 16'(seen), 16'd0);
    start0 = 1'b1; abort0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; abort0 = 1'b0;
    @(negedge clk);
    check_output("t4_abort_wins", {busy0, err0}, 16'b0010);
    fault0 = 0;
    pulse_start0();
    check_output("t4_rerun_clear", {busy0, pass0, err0, mask0}, 16'h100);
    wait_done0(40, cyc);
    check_output("t4_rerun_latency", 16'(cyc), 16'd16);
    @(negedge clk);
    check_output("t4_rerun_result", res0(), {4'd0, 3'b001, 3'd0, 4'b0000, 2'b00});

    $display("[TB] zero settle, start held high");
    fault1 = 2;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk);
    check_output("t5_first_drive", {busy1, a1, b1}, 16'b100);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      check_output($sformatf("t5_seq_%0d", k), {done1, a1, b1}, 16'(k / 2));
    end
    @(negedge clk);
    check_output("t5_done_at_8", {busy1, done1}, 16'b11);
    @(negedge clk);
    check_output("t5_idle_gap", {busy1, done1, pass1, err1, mask1}, {7'd0, 3'd4, 4'b0001});
    @(negedge clk);
    fault1 = 0;
    start1 = 1'b0;
    check_output("t5_second_accept", {busy1, a1, b1, err1, mask1}, {3'b100, 3'd0, 4'b0000});
    repeat (10) @(negedge clk);
    check_output("t5_second_result", {busy1, pass1, err1, mask1}, {2'b01, 3'd0, 4'b0000});

    $display("[TB] reset during check of vector 01");
    fault0 = 2;
    pulse_start0();
    repeat (7) @(negedge clk);
    check_output("t6_before_reset", {a0, b0, err0}, {2'b01, 3'd1});
    rst_n = 1'b0;
    #1;
    check_output("t6_async_clear", {a0, b0, res0()[11:0]}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done0 !== 1'b0 || busy0 !== 1'b0) seen++;
    end
    check_output("t6_no_done", 16'(seen), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

endmodule
